// File: rtl/display_pkg.sv
// Shared constants and state encoding for the hex-display arbiter.
package display_pkg;

  localparam int unsigned DISP_W    = 16;
  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DWELL_DEF = 50_000_000;
  localparam int unsigned CNT_W_DEF = 26;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StOwn  = ST_OWN
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or after start,
// optionally skipping one excluded index.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic [IDX_W-1:0] excl,
  input  logic             excl_en,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned      c;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = 32'(start) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cand = IDX_W'(c);
      if (!found && req[cand] && !(excl_en && cand == excl)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared hex display with minimum dwell time, lock
// and a one-cycle handover pulse. All outputs are registered.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DWELL = DWELL_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [DISP_W*N_REQ-1:0] req_data,
  input  logic                    lock,
  output logic [N_REQ-1:0]        grant,
  output logic [IDX_W-1:0]        owner,
  output logic [DISP_W-1:0]       disp_data,
  output logic                    disp_valid,
  output logic                    switch_pulse
);

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  state_e           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             expired;
  logic             take;
  logic [DISP_W-1:0] lane [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DISP_W +: DISP_W];
  end

  assign start   = (rr_last == LAST_IDX) ? '0 : rr_last + 1'b1;
  assign expired = (dwell_cnt == DWELL_MAX);

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .start   (start),
    .excl    (owner),
    .excl_en (state == StOwn),
    .found   (found),
    .idx     (pick)
  );

  // In OWN, found already means "others pending" since the owner is excluded.
  assign take = found && (state == StIdle || !req[owner] || (expired && !lock));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      grant        <= '0;
      owner        <= '0;
      disp_data    <= '0;
      disp_valid   <= 1'b0;
      switch_pulse <= 1'b0;
      dwell_cnt    <= '0;
      rr_last      <= LAST_IDX;
    end else begin
      switch_pulse <= 1'b0;
      if (take) begin
        state        <= StOwn;
        grant        <= N_REQ'(1) << pick;
        owner        <= pick;
        rr_last      <= pick;
        dwell_cnt    <= '0;
        disp_data    <= lane[pick];
        disp_valid   <= 1'b1;
        switch_pulse <= 1'b1;
      end else if (state == StOwn) begin
        if (!req[owner]) begin
          // Owner left with nobody waiting: disp_data and owner keep last values.
          state      <= StIdle;
          grant      <= '0;
          disp_valid <= 1'b0;
        end else begin
          disp_data <= lane[owner];
          if (!expired) dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic        lock;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        switch_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_arbiter #(
    .N_REQ (4),
    .DWELL (4),
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .lock         (lock),
    .grant        (grant),
    .owner        (owner),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .switch_pulse (switch_pulse)
  );

  // ---------------- behavioural model ----------------
  logic        m_own   = 1'b0;
  int          m_owner = 0;
  int          m_last  = N - 1;
  int          m_dwell = 0;
  logic [15:0] m_data  = 16'h0000;
  logic        m_pulse = 1'b0;
  logic [3:0]  exp_grant;

  function automatic int rr_next(logic [3:0] r, int last, int excl, logic use_excl);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c] && !(use_excl && c == excl)) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] lane(int i);
    return req_data[i*16 +: 16];
  endfunction

  task automatic take(int p);
    m_own   <= 1'b1;
    m_owner <= p;
    m_last  <= p;
    m_dwell <= 0;
    m_data  <= lane(p);
    m_pulse <= 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    int p;
    if (reset) begin
      m_own   <= 1'b0;
      m_owner <= 0;
      m_last  <= N - 1;
      m_dwell <= 0;
      m_data  <= 16'h0000;
      m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      p = rr_next(req, m_last, m_owner, m_own);
      if (!m_own) begin
        if (p >= 0) take(p);
      end else if (!req[m_owner]) begin
        if (p >= 0) take(p);
        else m_own <= 1'b0;
      end else if (m_dwell == DW - 1 && !lock && p >= 0) begin
        take(p);
      end else begin
        m_data  <= lane(m_owner);
        m_dwell <= (m_dwell + 1 < DW) ? m_dwell + 1 : DW - 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    exp_grant = m_own ? (4'b0001 << m_owner) : 4'b0000;
    checks++;
    if ({grant, owner, disp_data, disp_valid, switch_pulse} !==
        {exp_grant, 2'(m_owner), m_data, m_own, m_pulse}) begin
      failures++;
      $display("FAIL model t=%0t got grant=%b owner=%0d data=%h valid=%b pulse=%b exp grant=%b owner=%0d data=%h valid=%b pulse=%b",
               $time, grant, owner, disp_data, disp_valid, switch_pulse,
               exp_grant, m_owner, m_data, m_own, m_pulse);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner, 0);
    chk("rst_data", disp_data, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_pulse", switch_pulse, 0);
    reset = 1'b0;

    repeat (10) begin
      @(negedge clk);
      chk("idle_grant", grant, 0);
      chk("idle_valid", disp_valid, 0);
      chk("idle_pulse", switch_pulse, 0);
    end

    // First grant and one-cycle pulse
    req = 4'b0001;
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);
    chk("first_owner", owner, 0);
    chk("first_data", disp_data, 16'h1111);
    chk("first_pulse", switch_pulse, 1);
    @(negedge clk);
    chk("first_pulse_low", switch_pulse, 0);
    chk("first_grant_hold", grant, 4'b0001);

    // Owner leaves, nobody waiting: idle with held data
    req = 4'b0000;
    @(negedge clk);
    chk("drop_idle_valid", disp_valid, 0);
    chk("drop_idle_grant", grant, 0);
    chk("drop_idle_data", disp_data, 16'h1111);
    chk("drop_idle_owner", owner, 0);

    // Alternation with dwell 4: search resumes after last owner 0 -> picks 2
    req = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("alt_grant", grant, ((k / 4) % 2 == 0) ? 4'b0100 : 4'b0001);
      chk("alt_data", disp_data, ((k / 4) % 2 == 0) ? 16'h3333 : 16'h1111);
      chk("alt_pulse", switch_pulse, (k % 4 == 0) ? 1 : 0);
    end

    // Lock pins owner 0 while requester 1 waits
    req = 4'b0001;
    @(negedge clk);
    chk("lock_pre_grant", grant, 4'b0001);
    chk("lock_pre_pulse", switch_pulse, 1);
    req  = 4'b0011;
    lock = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("lock_hold_grant", grant, 4'b0001);
      chk("lock_hold_pulse", switch_pulse, 0);
    end
    lock = 1'b0;
    @(negedge clk);
    chk("unlock_grant", grant, 4'b0010);
    chk("unlock_data", disp_data, 16'h2222);
    chk("unlock_pulse", switch_pulse, 1);

    // Owner 0 drops at dwell 1 with requester 3 waiting
    req = 4'b0001;
    @(negedge clk);
    chk("drop_pre_grant", grant, 4'b0001);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("drop_grant", grant, 4'b1000);
    chk("drop_data", disp_data, 16'h4444);
    chk("drop_owner", owner, 3);
    chk("drop_pulse", switch_pulse, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("none_valid", disp_valid, 0);
    chk("none_grant", grant, 0);
    chk("none_data", disp_data, 16'h4444);
    chk("none_owner", owner, 3);
    chk("none_pulse", switch_pulse, 0);

    // Async reset between edges, then round-robin from index 0
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_grant", grant, 0);
    chk("async_owner", owner, 0);
    chk("async_data", disp_data, 0);
    chk("async_valid", disp_valid, 0);
    chk("async_pulse", switch_pulse, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_grant", grant, 4'b0001 << (k / 4));
      chk("rr_owner", owner, k / 4);
      chk("rr_data", disp_data, 16'(32'h1111 * (k / 4 + 1)));
      chk("rr_pulse", switch_pulse, (k % 4 == 0) ? 1 : 0);
    end

    // Sole requester keeps display with no re-grant
    req = 4'b0100;
    @(negedge clk);
    chk("sole_grant", grant, 4'b0100);
    chk("sole_pulse", switch_pulse, 1);
    repeat (9) begin
      @(negedge clk);
      chk("sole_hold_grant", grant, 4'b0100);
      chk("sole_hold_pulse", switch_pulse, 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
